data_mem: RTL and testbench

//  Word-organised data memory that sits directly downstream of the cpu data port.

---
 rtl/data_mem_if.sv | 19 +
 rtl/data_mem.sv | 65 ++++++
 tb/tb_data_mem.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/data_mem_if.sv
// Data-port bundle between the cpu (master) and the word-organised data memory (slave).
interface data_mem_if;
    logic [31:0] DMAdr;
    logic        DMcurWE;
    logic [1:0]  DMWLen;
    logic [31:0] DMDataW;
    logic [31:0] DMcurPC;
    logic [31:0] DMDataR;

    modport master (
        output DMAdr, DMcurWE, DMWLen, DMDataW, DMcurPC,
        input  DMDataR
    );

    modport slave (
        input  DMAdr, DMcurWE, DMWLen, DMDataW, DMcurPC,
        output DMDataR
    );
endinterface

// File: rtl/data_mem.sv
// Word-organised data memory with byte/half/word lane-merging stores and a combinational read.
// Define DM_WRITE_LOG_EN to print a log line for every committed store.
module data_mem #(
    parameter int WORDS_LOG2 = 12
) (
    input  logic       clk,
    input  logic       reset,
    data_mem_if.slave  bus
);
    localparam int DEPTH = 1 << WORDS_LOG2;

    typedef enum logic [1:0] {
        LEN_WORD = 2'b00,
        LEN_HALF = 2'b01,
        LEN_BYTE = 2'b10,
        LEN_RSVD = 2'b11
    } wlen_e;

    logic [31:0]           mem [DEPTH];
    logic [WORDS_LOG2-1:0] idx;
    wlen_e                 wlen;
    logic [31:0]           cur_word;
    logic [31:0]           merged_word;
    logic                  do_write;

    // High address bits wrap modulo the depth; the PC only feeds the optional log.
    logic unused_bits;
    assign unused_bits = ^{bus.DMAdr[31:WORDS_LOG2+2], bus.DMcurPC};

    assign idx      = bus.DMAdr[WORDS_LOG2+1:2];
    assign wlen     = wlen_e'(bus.DMWLen);
    assign cur_word = mem[idx];
    assign do_write = bus.DMcurWE && (wlen != LEN_RSVD);

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        merged_word = cur_word;
        case (wlen)
            LEN_WORD: merged_word = bus.DMDataW;
            LEN_HALF: begin
                if (bus.DMAdr[1]) merged_word[31:16] = bus.DMDataW[15:0];
                else              merged_word[15:0]  = bus.DMDataW[15:0];
            end
            LEN_BYTE: merged_word[{bus.DMAdr[1:0], 3'b000} +: 8] = bus.DMDataW[7:0];
            default:  merged_word = cur_word;
        endcase
    end

    // NOTE: the whole array is cleared asynchronously, so it maps to flops rather than a RAM
    // macro; sequential state uses non-blocking assignments so the merge reads the pre-edge word.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (do_write) begin
            mem[idx] <= merged_word;
`ifdef DM_WRITE_LOG_EN
            $display("%d@%h: *%h <= %h", $time, bus.DMcurPC, {bus.DMAdr[31:2], 2'b00}, merged_word);
`endif
        end
    end

    assign bus.DMDataR = reset ? 32'h0 : cur_word;
endmodule

// File: tb/tb_data_mem.sv
// Directed self-checking bench for data_mem: reset, lane merging, reserved width, wrap, reset-on-edge.
module tb_data_mem;
    localparam logic [1:0] W_WORD = 2'b00;
    localparam logic [1:0] W_HALF = 2'b01;
    localparam logic [1:0] W_BYTE = 2'b10;
    localparam logic [1:0] W_RSVD = 2'b11;

    logic clk;
    logic reset;
    int   checks;
    int   errors;
    logic [31:0] pc_cnt;

    data_mem_if bus ();

    data_mem #(.WORDS_LOG2(12)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic store(input logic [31:0] adr, input logic [1:0] len, input logic [31:0] data);
        @(negedge clk);
        bus.DMAdr   = adr;
        bus.DMWLen  = len;
        bus.DMDataW = data;
        bus.DMcurPC = pc_cnt;
        bus.DMcurWE = 1'b1;
        @(posedge clk);
        #1;
        bus.DMcurWE = 1'b0;
        pc_cnt      = pc_cnt + 32'd4;
    endtask

    task automatic read_word(input logic [31:0] adr, output logic [31:0] data);
        bus.DMAdr = adr;
        #1;
        data = bus.DMDataR;
    endtask

    task automatic test_reset();
        logic [31:0] rd;
        reset = 1'b1;
        #3;
        read_word(32'h0, rd);
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL reset_hold got=%h exp=%h", rd, 32'h0); end
        @(negedge clk);
        reset = 1'b0;
        store(32'h0000_0000, W_WORD, 32'h1111_2222);
        store(32'h0000_3FFC, W_WORD, 32'h3333_4444);
        read_word(32'h0, rd);
        checks++; if (rd !== 32'h1111_2222) begin errors++; $display("FAIL pre_pulse_0x0 got=%h exp=%h", rd, 32'h1111_2222); end
        // Async pulse inside one low half-period: no clock edge before the reads.
        @(negedge clk);
        #1 reset = 1'b1;
        #1;
        checks++; if (bus.DMDataR !== 32'h0) begin errors++; $display("FAIL pulse_high got=%h exp=%h", bus.DMDataR, 32'h0); end
        reset = 1'b0;
        read_word(32'h0, rd);
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL pulse_0x0 got=%h exp=%h", rd, 32'h0); end
        read_word(32'h3FFC, rd);
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL pulse_0x3ffc got=%h exp=%h", rd, 32'h0); end
    endtask

    task automatic test_word();
        logic [31:0] rd;
        logic [31:0] adrs [3] = '{32'h10, 32'h11, 32'h13};
        store(32'h10, W_WORD, 32'h1234_5678);
        for (int i = 0; i < 3; i++) begin
            read_word(adrs[i], rd);
            checks++; if (rd !== 32'h1234_5678) begin errors++; $display("FAIL word_read@%h got=%h exp=%h", adrs[i], rd, 32'h1234_5678); end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd;
        logic [7:0]  bytes [4] = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
        for (int i = 0; i < 4; i++) store(32'h20 + 32'(i), W_BYTE, {24'hFFFFFF, bytes[i]});
        read_word(32'h20, rd);
        checks++; if (rd !== 32'hDDCC_BBAA) begin errors++; $display("FAIL bytes got=%h exp=%h", rd, 32'hDDCCBBAA); end
        store(32'h22, W_HALF, 32'h0000_BEEF);
        read_word(32'h20, rd);
        checks++; if (rd !== 32'hBEEF_BBAA) begin errors++; $display("FAIL half_hi got=%h exp=%h", rd, 32'hBEEFBBAA); end
        store(32'h21, W_HALF, 32'hFFFF_1234);
        read_word(32'h20, rd);
        checks++; if (rd !== 32'hBEEF_1234) begin errors++; $display("FAIL half_lo_odd got=%h exp=%h", rd, 32'hBEEF1234); end
        store(32'h20, W_BYTE, 32'hFFFF_FF55);
        read_word(32'h23, rd);
        checks++; if (rd !== 32'hBEEF_1255) begin errors++; $display("FAIL byte0 got=%h exp=%h", rd, 32'hBEEF1255); end
    endtask

    task automatic test_read_during_write();
        @(negedge clk);
        bus.DMAdr   = 32'h10;
        bus.DMWLen  = W_WORD;
        bus.DMDataW = 32'hA5A5_A5A5;
        bus.DMcurWE = 1'b1;
        #1;
        checks++; if (bus.DMDataR !== 32'h1234_5678) begin errors++; $display("FAIL rdw_old got=%h exp=%h", bus.DMDataR, 32'h12345678); end
        @(posedge clk);
        #1;
        bus.DMcurWE = 1'b0;
        checks++; if (bus.DMDataR !== 32'hA5A5_A5A5) begin errors++; $display("FAIL rdw_new got=%h exp=%h", bus.DMDataR, 32'hA5A5A5A5); end
    endtask

    task automatic test_no_write();
        logic [31:0] rd;
        store(32'h30, W_RSVD, 32'hFFFF_FFFF);
        read_word(32'h30, rd);
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL reserved got=%h exp=%h", rd, 32'h0); end
        @(negedge clk);
        bus.DMAdr   = 32'h34;
        bus.DMWLen  = W_WORD;
        bus.DMDataW = 32'h9999_9999;
        bus.DMcurWE = 1'b0;
        @(posedge clk);
        read_word(32'h34, rd);
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL we_low got=%h exp=%h", rd, 32'h0); end
    endtask

    task automatic test_wrap();
        logic [31:0] rd;
        store(32'h0001_0004, W_WORD, 32'hCAFE_F00D);
        read_word(32'h4, rd);
        checks++; if (rd !== 32'hCAFE_F00D) begin errors++; $display("FAIL wrap got=%h exp=%h", rd, 32'hCAFEF00D); end
        read_word(32'h0, rd);
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL wrap_neighbour got=%h exp=%h", rd, 32'h0); end
    endtask

    task automatic test_reset_on_edge();
        logic [31:0] rd;
        @(negedge clk);
        bus.DMAdr   = 32'h40;
        bus.DMWLen  = W_WORD;
        bus.DMDataW = 32'h7777_7777;
        bus.DMcurWE = 1'b1;
        #4 reset = 1'b1;
        @(posedge clk);
        #1;
        checks++; if (bus.DMDataR !== 32'h0) begin errors++; $display("FAIL edge_reset_out got=%h exp=%h", bus.DMDataR, 32'h0); end
        bus.DMcurWE = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        read_word(32'h40, rd);
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL edge_store got=%h exp=%h", rd, 32'h0); end
        read_word(32'h20, rd);
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL edge_clear got=%h exp=%h", rd, 32'h0); end
        // First edge after release must already accept a store.
        store(32'h40, W_BYTE, 32'h0000_0042);
        read_word(32'h40, rd);
        checks++; if (rd !== 32'h0000_0042) begin errors++; $display("FAIL post_release got=%h exp=%h", rd, 32'h42); end
    endtask

    initial begin
        checks      = 0;
        errors      = 0;
        pc_cnt      = 32'h0000_1000;
        bus.DMAdr   = '0;
        bus.DMcurWE = 1'b0;
        bus.DMWLen  = W_WORD;
        bus.DMDataW = '0;
        bus.DMcurPC = '0;
        test_reset();
        test_word();
        test_back_to_back();
        test_read_during_write();
        test_no_write();
        test_wrap();
        test_reset_on_edge();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
